rv32i_run_ctrl: RTL and testbench

//  Run controller for the rv32i core: sequences core reset, gates execution, counts

---
 rtl/rv32i_run_ctrl_if.sv | 29 ++
 rtl/rv32i_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_rv32i_run_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_run_ctrl_if.sv
// Run-controller bus: start request and core observation in, status out.
// master = top level / testbench, slave = rv32i_run_ctrl.
interface rv32i_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic [31:0]      instruccion;
    logic [31:0]      pc;
    logic             core_reset;
    logic             core_en;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output start, instruccion, pc,
        input  core_reset, core_en, busy, done, timeout,
        input  halt_cause, cycle_cnt, instr_cnt
    );

    modport slave (
        input  start, instruccion, pc,
        output core_reset, core_en, busy, done, timeout,
        output halt_cause, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/rv32i_run_ctrl.sv
// Run controller for rv32i: reset sequencing, execute gating, counters, halt/timeout.
// Ports: clk_RV, reset (async, active-high), bus (rv32i_run_ctrl_if.slave).
module rv32i_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned MAX_CYCLES  = 2000,
    parameter int unsigned CNT_W       = 32,
    parameter logic [2:0]  HALT_EN     = 3'b111,
    parameter int unsigned LOOP_REPEAT = 2
) (
    input  logic               clk_RV,
    input  logic               reset,
    rv32i_run_ctrl_if.slave    bus
);
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;

    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
    localparam int unsigned LCW = $clog2(LOOP_REPEAT + 1);

    localparam logic [RCW-1:0]   RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [LCW-1:0]   LOOP_LAST = LCW'(LOOP_REPEAT - 1);
    localparam logic [LCW-1:0]   LOOP_MAX  = LCW'(LOOP_REPEAT);
    localparam logic [CNT_W-1:0] CNT_LAST  =
        CNT_W'(MAX_CYCLES == 0 ? 0 : MAX_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

    state_t           state;
    logic [RCW-1:0]   rst_cnt;
    logic [LCW-1:0]   loop_cnt;
    logic [31:0]      prev_pc;
    logic             have_prev;
    logic             core_reset;
    logic             core_en;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    logic       is_ebreak;
    logic       is_ecall;
    logic       same_pc;
    logic       is_loop;
    logic       tmo_hit;
    logic       halt;
    logic [1:0] cause_n;

    assign bus.core_reset = core_reset;
    assign bus.core_en    = core_en;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.timeout    = timeout;
    assign bus.halt_cause = halt_cause;
    assign bus.cycle_cnt  = cycle_cnt;
    assign bus.instr_cnt  = instr_cnt;

    // loop_cnt holds how many consecutive repeats preceded this cycle,
    // so the current repeat is the LOOP_REPEAT-th one when it reaches LOOP_LAST.
    always_comb begin
        is_ebreak = HALT_EN[0] && (bus.instruccion == EBREAK);
        is_ecall  = HALT_EN[1] && (bus.instruccion == ECALL);
        same_pc   = have_prev && (bus.pc == prev_pc);
        is_loop   = HALT_EN[2] && same_pc && (loop_cnt >= LOOP_LAST);
        tmo_hit   = (MAX_CYCLES != 0) && (cycle_cnt == CNT_LAST);
        halt      = is_ebreak || is_ecall || is_loop;
        cause_n   = 2'd0;
        if (is_ebreak) begin
            cause_n = 2'd1;
        end else if (is_ecall) begin
            cause_n = 2'd2;
        end else if (is_loop) begin
            cause_n = 2'd3;
        end
    end

    always_ff @(posedge clk_RV or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            loop_cnt   <= '0;
            prev_pc    <= '0;
            have_prev  <= 1'b0;
            core_reset <= 1'b1;
            core_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            halt_cause <= 2'd0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= RST;
                        core_reset <= 1'b1;
                        core_en    <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        halt_cause <= 2'd0;
                        cycle_cnt  <= '0;
                        instr_cnt  <= '0;
                        rst_cnt    <= '0;
                        loop_cnt   <= '0;
                        have_prev  <= 1'b0;
                    end
                end
                RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        core_en    <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!(&cycle_cnt)) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    if ((bus.instruccion != 32'h0) && !(&instr_cnt)) begin
                        instr_cnt <= instr_cnt + 1'b1;
                    end
                    prev_pc   <= bus.pc;
                    have_prev <= 1'b1;
                    if (!same_pc) begin
                        loop_cnt <= '0;
                    end else if (loop_cnt != LOOP_MAX) begin
                        loop_cnt <= loop_cnt + 1'b1;
                    end
                    if (halt || tmo_hit) begin
                        state      <= DONE;
                        core_en    <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        timeout    <= tmo_hit;
                        halt_cause <= cause_n;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Scoreboard bench for rv32i_run_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares status snapshots and run results.
module tb_rv32i_run_ctrl;
    localparam int CW = 32;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] JAL    = 32'h0000_006F;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dprev = 1'b0;

    always #5 clk = ~clk;

    rv32i_run_ctrl_if #(.CNT_W(CW)) bus ();

    rv32i_run_ctrl #(
        .RST_CYCLES (4),
        .MAX_CYCLES (2000),
        .CNT_W      (CW),
        .HALT_EN    (3'b101),
        .LOOP_REPEAT(2)
    ) dut (
        .clk_RV(clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string         name;
        logic          cr;
        logic          ce;
        logic          bz;
        logic          dn;
        logic          to;
        logic [1:0]    hc;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ins;
    } exp_t;

    exp_t stat_q[$];
    exp_t res_q[$];
    int total = 0;
    int bad = 0;

    function automatic exp_t mk(string n, bit cr, bit ce, bit bz, bit dn,
                                bit to, int hc, int cyc, int ins);
        exp_t e;
        e.name = n;
        e.cr   = cr;
        e.ce   = ce;
        e.bz   = bz;
        e.dn   = dn;
        e.to   = to;
        e.hc   = 2'(hc);
        e.cyc  = CW'(cyc);
        e.ins  = CW'(ins);
        return e;
    endfunction

    task automatic check(exp_t e);
        logic [2*CW+6:0] act;
        logic [2*CW+6:0] req;
        act = {bus.core_reset, bus.core_en, bus.busy, bus.done, bus.timeout,
               bus.halt_cause, bus.cycle_cnt, bus.instr_cnt};
        req = {e.cr, e.ce, e.bz, e.dn, e.to, e.hc, e.cyc, e.ins};
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got cr=%b ce=%b busy=%b done=%b to=%b cause=%0d cyc=%0d ins=%0d | want cr=%b ce=%b busy=%b done=%b to=%b cause=%0d cyc=%0d ins=%0d",
                     e.name, bus.core_reset, bus.core_en, bus.busy, bus.done,
                     bus.timeout, bus.halt_cause, bus.cycle_cnt, bus.instr_cnt,
                     e.cr, e.ce, e.bz, e.dn, e.to, e.hc, e.cyc, e.ins);
        end
    endtask

    // Monitor: status snapshots are checked at the negedge after they are
    // queued; a run result is popped whenever done rises.
    initial begin
        forever begin
            @(negedge clk);
            while (stat_q.size() > 0) begin
                check(stat_q.pop_front());
            end
            if (bus.done && !dprev) begin
                if (res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got cause=%0d cyc=%0d, want no run end",
                             bus.halt_cause, bus.cycle_cnt);
                end else begin
                    check(res_q.pop_front());
                end
            end
            dprev = bus.done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [31:0] i, logic [31:0] p);
        bus.instruccion = i;
        bus.pc = p;
        tick();
    endtask

    // start pulse plus the four RST cycles; returns just after RUN entry
    task automatic go();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.instruccion = 32'h0;
        bus.pc = 32'h0;
        reset = 1'b1;
        tick();
        tick();
        stat_q.push_back(mk("reset_state", 1, 0, 0, 0, 0, 0, 0, 0));
        tick();
        reset = 1'b0;
        tick();
        stat_q.push_back(mk("idle", 1, 0, 0, 0, 0, 0, 0, 0));

        // reset sequencing
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        stat_q.push_back(mk("rst_c1", 1, 0, 1, 0, 0, 0, 0, 0));
        tick();
        tick();
        tick();
        stat_q.push_back(mk("rst_c4", 1, 0, 1, 0, 0, 0, 0, 0));
        tick();
        stat_q.push_back(mk("run_entry", 0, 1, 1, 0, 0, 0, 0, 0));

        // EBREAK on 10th run cycle, zeros on cycles 3 and 6
        res_q.push_back(mk("ebreak", 0, 0, 0, 1, 0, 1, 10, 8));
        for (int k = 1; k <= 9; k++) begin
            drive((k == 3 || k == 6) ? 32'h0 : ADDI, 32'(k * 4));
            if (k == 5) stat_q.push_back(mk("run5", 0, 1, 1, 0, 0, 0, 5, 4));
        end
        drive(EBREAK, 32'd40);
        tick();
        stat_q.push_back(mk("done_hold", 0, 0, 0, 1, 0, 1, 10, 8));

        // restart from DONE, ECALL masked, start in RUN ignored, self-loop
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        stat_q.push_back(mk("restart_clr", 1, 0, 1, 0, 0, 0, 0, 0));
        repeat (4) tick();
        res_q.push_back(mk("selfloop", 0, 0, 0, 1, 0, 3, 7, 7));
        drive(ECALL, 32'd0);
        drive(ECALL, 32'd4);
        drive(ECALL, 32'd8);
        stat_q.push_back(mk("ecall_off", 0, 1, 1, 0, 0, 0, 3, 3));
        bus.start = 1'b1;
        drive(ADDI, 32'd12);
        bus.start = 1'b0;
        stat_q.push_back(mk("start_in_run", 0, 1, 1, 0, 0, 0, 4, 4));
        drive(JAL, 32'd100);
        drive(JAL, 32'd100);
        stat_q.push_back(mk("loop_pending", 0, 1, 1, 0, 0, 0, 6, 6));
        drive(JAL, 32'd100);
        tick();

        // pure timeout, every 5th instruction zero
        go();
        res_q.push_back(mk("timeout", 0, 0, 0, 1, 1, 0, 2000, 1600));
        for (int k = 1; k <= 2000; k++) begin
            drive((k % 5 == 0) ? 32'h0 : ADDI, 32'(k * 4));
            if (k == 1999) stat_q.push_back(mk("tmo_m1", 0, 1, 1, 0, 0, 0, 1999, 1600));
        end
        tick();

        // asynchronous reset in the middle of a run
        go();
        for (int k = 1; k <= 5; k++) begin
            drive(ADDI, 32'(k * 4));
            if (k == 4) stat_q.push_back(mk("run4", 0, 1, 1, 0, 0, 0, 4, 4));
        end
        reset = 1'b1;
        stat_q.push_back(mk("async_rst", 1, 0, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b1;
        tick();
        tick();
        stat_q.push_back(mk("held_rst", 1, 0, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b0;
        reset = 1'b0;
        tick();
        stat_q.push_back(mk("idle_after", 1, 0, 0, 0, 0, 0, 0, 0));
        tick();

        // EBREAK on the last budget cycle: cause and timeout together
        go();
        res_q.push_back(mk("halt_and_tmo", 0, 0, 0, 1, 1, 1, 2000, 2000));
        for (int k = 1; k <= 2000; k++) begin
            drive((k == 2000) ? EBREAK : ADDI, 32'(k * 4));
        end
        tick();
        tick();

        while (res_q.size() > 0) begin
            exp_t e;
            e = res_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got no done rise, want done=1 cause=%0d cyc=%0d",
                     e.name, e.hc, e.cyc);
        end
        while (stat_q.size() > 0) begin
            exp_t e;
            e = stat_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got unchecked snapshot, want checked", e.name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
